// File: rtl/mult_pkg.sv
// Shared constants and helpers for the signed shift-add multiplier datapath.
package mult_pkg;

  localparam int WIDTH = 8;

  // Widen an operand by one bit so {X,A} arithmetic never overflows.
  function automatic logic [WIDTH:0] sext(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// Control strobes, switch operand and register views of the multiplier datapath.
interface mult_datapath_if;
  import mult_pkg::*;

  logic             ClearA_LoadB;
  logic             CLRA;
  logic             Shift_En;
  logic             LD;
  logic             SUB;
  logic [WIDTH-1:0] S;
  logic             X;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             M;

  modport master (
    output ClearA_LoadB, CLRA, Shift_En, LD, SUB, S,
    input  X, Aval, Bval, M
  );

  modport slave (
    input  ClearA_LoadB, CLRA, Shift_En, LD, SUB, S,
    output X, Aval, Bval, M
  );

endinterface

// File: rtl/mult_datapath_add_sub9.sv
// Ripple-carry adder/subtractor over the sign-extended {X,A} width.
module add_sub9
  import mult_pkg::*;
(
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] s
);

  logic [WIDTH:0] b_x;
  logic [WIDTH:0] carry;

  // Subtraction is a + ~b + 1; the final carry-out is not needed.
  assign b_x      = b ^ {(WIDTH + 1){sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sum
    assign s[i] = a[i] ^ b_x[i] ^ carry[i];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
  end

endmodule

// File: rtl/mult_datapath.sv
// X/A/B registers of the signed shift-add multiplier: load, clear, add-then-shift.
module mult_datapath
  import mult_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  mult_datapath_if.slave  bus
);

  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   xa;
  logic [WIDTH:0]   operand;
  logic [WIDTH:0]   addsub;
  logic [WIDTH:0]   sum9;

  assign xa      = {x_q, a_q};
  assign operand = sext(bus.S);

  add_sub9 u_add_sub9 (
    .a   (xa),
    .b   (operand),
    .sub (bus.SUB),
    .s   (addsub)
  );

  // The add only happens when the multiplier bit currently in B[0] is set.
  assign sum9 = (bus.LD && b_q[0]) ? addsub : xa;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    if (bus.ClearA_LoadB) begin
      x_d = 1'b0;
      a_d = '0;
      b_d = bus.S;
    end else if (bus.CLRA) begin
      x_d = 1'b0;
      a_d = '0;
    end else if (bus.Shift_En) begin
      x_d = sum9[WIDTH];
      a_d = sum9[WIDTH:1];
      b_d = {sum9[0], b_q[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign bus.X    = x_q;
  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.M    = b_q[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench: directed and random signed multiplies against an arithmetic product model.
module tb_mult_datapath;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  mult_datapath_if dif ();

  mult_datapath dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (dif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    dif.ClearA_LoadB = 1'b0;
    dif.CLRA         = 1'b0;
    dif.Shift_En     = 1'b0;
    dif.LD           = 1'b0;
    dif.SUB          = 1'b0;
  endtask

  // Reference: {X,A,B} of a completed run is the 16-bit signed product with X as its sign.
  function automatic logic [16:0] ref_product(input logic [7:0] b, input logic [7:0] s);
    int          prod;
    logic [15:0] p16;
    prod = int'($signed(b)) * int'($signed(s));
    p16  = prod[15:0];
    return {(prod < 0), p16};
  endfunction

  task automatic check_state(input string name, input logic [16:0] exp);
    logic [16:0] got;
    got = {dif.X, dif.Aval, dif.Bval};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got X=%b A=%h B=%h, expected X=%b A=%h B=%h",
               name, got[16], got[15:8], got[7:0], exp[16], exp[15:8], exp[7:0]);
    end
    total++;
    if (dif.M !== exp[0]) begin
      bad++;
      $display("FAIL %s M: got %b, expected %b", name, dif.M, exp[0]);
    end
  endtask

  task automatic do_load(input logic [7:0] b);
    idle_inputs();
    dif.ClearA_LoadB = 1'b1;
    dif.S            = b;
    step();
    dif.ClearA_LoadB = 1'b0;
  endtask

  task automatic do_shifts(input logic [7:0] s, input int n);
    dif.S  = s;
    dif.LD = 1'b1;
    for (int i = 0; i < n; i++) begin
      dif.Shift_En = 1'b1;
      dif.SUB      = (i == 7);
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    dif.S = 8'hA5;
    Reset = 1'b0;
    do_load(8'h93);
    do_shifts(8'h6C, 3);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_state("reset", 17'h0);
  endtask

  task automatic test_directed();
    logic [7:0] bs [3];
    logic [7:0] ss [3];
    bs = '{8'h07, 8'hFD, 8'h80};
    ss = '{8'hFD, 8'h07, 8'h80};
    for (int k = 0; k < 3; k++) begin
      do_load(bs[k]);
      check_state("load", {9'h0, bs[k]});
      do_shifts(ss[k], 8);
      check_state("directed_mul", ref_product(bs[k], ss[k]));
    end
    total++;
    if ({dif.X, dif.Aval, dif.Bval} !== 17'h04000) begin
      bad++;
      $display("FAIL extreme: got %h, expected 04000", {dif.X, dif.Aval, dif.Bval});
    end
  endtask

  task automatic test_hold();
    logic [16:0] exp;
    do_load(8'hC9);
    do_shifts(8'h5B, 8);
    exp = ref_product(8'hC9, 8'h5B);
    for (int i = 0; i < 5; i++) begin
      dif.Shift_En = 1'b0;
      dif.LD       = 1'b1;
      dif.SUB      = 1'b1;
      dif.S        = 8'($urandom);
      step();
      check_state("hold", exp);
    end
    idle_inputs();
  endtask

  task automatic test_abort_and_clear();
    logic [16:0] exp;
    do_load(8'h3D);
    do_shifts(8'hE7, 4);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_state("abort_reset", 17'h0);

    do_load(8'h5A);
    dif.CLRA = 1'b1;
    step();
    dif.CLRA = 1'b0;
    check_state("clra_after_load", {9'h0, 8'h5A});

    do_load(8'hB7);
    do_shifts(8'h9E, 8);
    exp = ref_product(8'hB7, 8'h9E);
    dif.CLRA = 1'b1;
    step();
    dif.CLRA = 1'b0;
    check_state("clra_after_mul", {9'h0, exp[7:0]});
  endtask

  task automatic test_priority();
    logic [16:0] exp;
    do_load(8'h6B);
    do_shifts(8'hF1, 8);
    exp = ref_product(8'h6B, 8'hF1);
    // CLRA outranks a shift with add enabled
    dif.CLRA     = 1'b1;
    dif.Shift_En = 1'b1;
    dif.LD       = 1'b1;
    dif.S        = 8'h44;
    step();
    idle_inputs();
    check_state("clra_over_shift", {9'h0, exp[7:0]});
    // load outranks CLRA and shift
    dif.ClearA_LoadB = 1'b1;
    dif.CLRA         = 1'b1;
    dif.Shift_En     = 1'b1;
    dif.LD           = 1'b1;
    dif.S            = 8'h2F;
    step();
    idle_inputs();
    check_state("load_over_all", {9'h0, 8'h2F});
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] s;
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      s = 8'($urandom);
      if (k == 0) b = 8'h00;
      if (k == 1) s = 8'h7F;
      if (k == 2) b = 8'hFF;
      do_load(b);
      do_shifts(s, 8);
      check_state("random_mul", ref_product(b, s));
      step();
      check_state("random_mul_held", ref_product(b, s));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    idle_inputs();
    dif.S = 8'h00;
    step();
    Reset = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_abort_and_clear();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
